// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the unified-memory arbiter: FSM state encoding,
// owner encoding, default geometry/latency constants and a small helper that
// sizes counters from their maximum value.
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

  // Geometry matches the core's instruction/data width (ISIZE = 16).
  localparam int DEF_ASIZE      = 16;
  localparam int DEF_DSIZE      = 16;
  localparam int DEF_MEM_LAT    = 2;
  localparam int DEF_STARVE_MAX = 3;

  // Wait counter width; covers the full legal MEM_LAT range of 1..15.
  localparam int LAT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arbState_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  // Bits needed to hold 0..maxVal (at least one bit).
  function automatic int cntWidth(input int maxVal);
    return (maxVal < 2) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// -----------------------------------------------------------------------------
// mem_arb_pick
// Owner selector for the memory arbiter plus the saturating starve counter
// that stops a stream of data accesses from locking out instruction fetch.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   pickEn       arbiter is in IDLE and at least one request is present
//   idle         arbiter is in IDLE
//   ifReq/dmReq  current fetch / data request levels
//   pickDm       combinational decision: 1 = DM wins this pick
//   owner        registered owner of the transaction in flight
//   starveCnt    consecutive DM grants taken while IF was waiting
// -----------------------------------------------------------------------------
module mem_arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                pickEn,
  input  logic                                idle,
  input  logic                                ifReq,
  input  logic                                dmReq,
  output logic                                pickDm,
  output owner_t                              owner,
  output logic [cntWidth(STARVE_MAX)-1:0]     starveCnt
);

  localparam int SW = cntWidth(STARVE_MAX);

  logic starved;
  logic forceIf;

  assign starved = (starveCnt == SW'(STARVE_MAX));
  // DM is the older instruction and normally wins; IF wins only once it has
  // been passed over STARVE_MAX times in a row.
  assign forceIf = ifReq && starved;
  assign pickDm  = dmReq && !forceIf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner     <= OWN_IF;
      starveCnt <= '0;
    end else if (pickEn) begin
      if (pickDm) begin
        owner <= OWN_DM;
        if (!ifReq) begin
          starveCnt <= '0;
        end else if (!starved) begin
          starveCnt <= starveCnt + SW'(1);
        end
      end else begin
        owner     <= OWN_IF;
        starveCnt <= '0;
      end
    end else if (idle && !ifReq) begin
      starveCnt <= '0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares the single-ported unified memory between instruction fetch (IF) and
// the MEM-stage data port (DM). Each access runs IDLE -> ISSUE -> WAIT -> RESP:
// one mem_en cycle, MEM_LAT cycles of latency, then a one-cycle ack carrying
// the read data. Stall requests are raised while a request is unacknowledged.
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   if_req/if_addr          fetch request (level, held until if_ack) + address
//   if_rdata/if_ack         fetched word, valid during the one-cycle if_ack
//   dm_req/dm_we/dm_addr    data request (level), 1 = store, address
//   dm_wdata                store data
//   dm_rdata/dm_ack         load data, valid during the one-cycle dm_ack
//   mem_en/mem_we           registered memory enable / write enable
//   mem_addr/mem_wdata      registered memory address / write data
//   mem_rdata               memory read data, valid MEM_LAT cycles after mem_en
//   stall_if/stall_mem      pipeline stall requests
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ASIZE      = DEF_ASIZE,
  parameter int DSIZE      = DEF_DSIZE,
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_req,
  input  logic [ASIZE-1:0] if_addr,
  output logic [DSIZE-1:0] if_rdata,
  output logic             if_ack,
  input  logic             dm_req,
  input  logic             dm_we,
  input  logic [ASIZE-1:0] dm_addr,
  input  logic [DSIZE-1:0] dm_wdata,
  output logic [DSIZE-1:0] dm_rdata,
  output logic             dm_ack,
  output logic             mem_en,
  output logic             mem_we,
  output logic [ASIZE-1:0] mem_addr,
  output logic [DSIZE-1:0] mem_wdata,
  input  logic [DSIZE-1:0] mem_rdata,
  output logic             stall_if,
  output logic             stall_mem
);

  arbState_t                       state;
  logic [LAT_W-1:0]                waitCnt;
  logic                            cancelled;
  logic                            isStore;
  logic                            anyReq;
  logic                            pickEn;
  logic                            pickDm;
  logic                            ownerReq;
  owner_t                          owner;
  logic [cntWidth(STARVE_MAX)-1:0] starveCnt;

  assign anyReq = if_req || dm_req;
  assign pickEn = (state == IDLE) && anyReq;

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .clk       (clk),
    .rst_n     (rst_n),
    .pickEn    (pickEn),
    .idle      (state == IDLE),
    .ifReq     (if_req),
    .dmReq     (dm_req),
    .pickDm    (pickDm),
    .owner     (owner),
    .starveCnt (starveCnt)
  );

  // Request level of whoever owns the transaction in flight; dropping it
  // before the response squashes the ack (branch/JR fetch cancel).
  assign ownerReq = (owner == OWN_DM) ? dm_req : if_req;

  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = dm_req & ~dm_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      waitCnt   <= '0;
      cancelled <= 1'b0;
      isStore   <= 1'b0;
    end else begin
      // Acks are single-cycle pulses.
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (anyReq) begin
            state     <= ISSUE;
            mem_en    <= 1'b1;
            cancelled <= 1'b0;
            if (pickDm) begin
              mem_we    <= dm_we;
              isStore   <= dm_we;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
            end else begin
              mem_we    <= 1'b0;
              isStore   <= 1'b0;
              mem_addr  <= if_addr;
            end
          end
        end
        ISSUE: begin
          // The memory sees the access during this cycle only.
          mem_en  <= 1'b0;
          mem_we  <= 1'b0;
          waitCnt <= LAT_W'(MEM_LAT);
          if (!ownerReq) begin
            cancelled <= 1'b1;
          end
          state <= WAIT;
        end
        WAIT: begin
          waitCnt <= waitCnt - LAT_W'(1);
          if (waitCnt == LAT_W'(1)) begin
            // mem_rdata is valid now, MEM_LAT cycles after the ISSUE cycle.
            state <= RESP;
            if (ownerReq && !cancelled) begin
              if (owner == OWN_IF) begin
                if_rdata <= mem_rdata;
                if_ack   <= 1'b1;
              end else begin
                if (!isStore) begin
                  dm_rdata <= mem_rdata;
                end
                dm_ack <= 1'b1;
              end
            end
          end else if (!ownerReq) begin
            cancelled <= 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (MEM_LAT=2, STARVE_MAX=3). Each test counts
// cycles from the cycle in which its first request is presented (cycle 0).
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_ack;
  logic        dm_req;
  logic        dm_we;
  logic [15:0] dm_addr;
  logic [15:0] dm_wdata;
  logic [15:0] dm_rdata;
  logic        dm_ack;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        stall_if;
  logic        stall_mem;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(
    .ASIZE(16), .DSIZE(16), .MEM_LAT(2), .STARVE_MAX(3)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: two-stage read pipe gives data MEM_LAT=2 cycles after mem_en.
  logic [15:0] memArr [0:4095];
  logic [15:0] pipe0, pipe1;
  always @(posedge clk) begin
    pipe0 <= (mem_en && !mem_we) ? memArr[mem_addr[11:0]] : 16'hDEAD;
    pipe1 <= pipe0;
    if (mem_en && mem_we) memArr[mem_addr[11:0]] <= mem_wdata;
  end
  assign mem_rdata = pipe1;

  // One line per completed transaction.
  always @(negedge clk) begin
    if (if_ack) $display("txn IF ack   rdata=%h  t=%0t", if_rdata, $time);
    if (dm_ack) $display("txn DM ack   rdata=%h  t=%0t", dm_rdata, $time);
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) memArr[i] = 16'(i);
    memArr[12'h010] = 16'hB123;
    memArr[12'h200] = 16'h1234;
    memArr[12'h300] = 16'h0F0F;
    rst_n = 1'b0; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkVal("rst_mem_en", mem_en, 0);
    checkVal("rst_mem_we", mem_we, 0);
    checkVal("rst_acks", {if_ack, dm_ack}, 0);
    checkVal("rst_addr", mem_addr, 0);
    checkVal("rst_wdata", mem_wdata, 0);
    checkVal("rst_rdata", {if_rdata, dm_rdata}, 0);
    checkVal("rst_stall", {stall_if, stall_mem}, 0);
    checkVal("rst_starve", dut.u_pick.starveCnt, 0);
    nextCycle();
    rst_n = 1'b1;
    repeat (2) nextCycle();

    // T1: single IF read of 0x0010.
    for (int c = 0; c <= 5; c++) begin
      nextCycle();
      if (c == 0) begin if_req = 1; if_addr = 16'h0010; end
      if (c == 5) if_req = 0;
      @(negedge clk);
      checkVal("t1_mem_en", mem_en, c == 1);
      if (c == 1) checkVal("t1_mem_addr", mem_addr, 16'h0010);
      checkVal("t1_if_ack", if_ack, c == 4);
      if (c == 4) checkVal("t1_if_rdata", if_rdata, 16'hB123);
      checkVal("t1_stall_if", stall_if, c <= 3);
    end

    // T2: simultaneous IF (0x0010) and DM load (0x0200); DM goes first.
    for (int c = 0; c <= 10; c++) begin
      nextCycle();
      if (c == 0) begin
        if_req = 1; if_addr = 16'h0010;
        dm_req = 1; dm_we = 0; dm_addr = 16'h0200;
      end
      if (c == 5) dm_req = 0;
      if (c == 10) if_req = 0;
      @(negedge clk);
      checkVal("t2_mem_en", mem_en, (c == 1) || (c == 6));
      if (c == 1) checkVal("t2_addr_dm", mem_addr, 16'h0200);
      if (c == 6) checkVal("t2_addr_if", mem_addr, 16'h0010);
      checkVal("t2_dm_ack", dm_ack, c == 4);
      if (c == 4) checkVal("t2_dm_rdata", dm_rdata, 16'h1234);
      checkVal("t2_if_ack", if_ack, c == 9);
      if (c == 9) checkVal("t2_if_rdata", if_rdata, 16'hB123);
      checkVal("t2_stall_mem", stall_mem, c <= 3);
      checkVal("t2_stall_if", stall_if, c <= 8);
    end

    // T3: both held: DM, DM, DM, IF (forced), DM.
    for (int c = 0; c <= 26; c++) begin
      nextCycle();
      if (c == 0) begin
        if_req = 1; if_addr = 16'h0010;
        dm_req = 1; dm_we = 0; dm_addr = 16'h0200;
      end
      if (c == 25) begin if_req = 0; dm_req = 0; end
      @(negedge clk);
      checkVal("t3_dm_ack", dm_ack, (c == 4) || (c == 9) || (c == 14) || (c == 24));
      checkVal("t3_if_ack", if_ack, c == 19);
      if (c == 19) checkVal("t3_if_rdata", if_rdata, 16'hB123);
      if (c == 16) checkVal("t3_if_addr", mem_addr, 16'h0010);
      checkVal("t3_stall_if", stall_if, (c <= 24) && (c != 19));
      if (c == 1)  checkVal("t3_starve1", dut.u_pick.starveCnt, 1);
      if (c == 11) checkVal("t3_starve3", dut.u_pick.starveCnt, 3);
      if (c == 16) checkVal("t3_starve_clr", dut.u_pick.starveCnt, 0);
      if (c == 21) checkVal("t3_starve_re", dut.u_pick.starveCnt, 1);
      if (c == 26) checkVal("t3_starve_idle", dut.u_pick.starveCnt, 0);
    end

    // T4: DM store 0x55AA -> 0x0300; dm_rdata keeps last load value.
    for (int c = 0; c <= 5; c++) begin
      nextCycle();
      if (c == 0) begin dm_req = 1; dm_we = 1; dm_addr = 16'h0300; dm_wdata = 16'h55AA; end
      if (c == 5) begin dm_req = 0; dm_we = 0; end
      @(negedge clk);
      checkVal("t4_mem_en", mem_en, c == 1);
      checkVal("t4_mem_we", mem_we, c == 1);
      if (c == 1) checkVal("t4_addr", mem_addr, 16'h0300);
      if (c == 1) checkVal("t4_wdata", mem_wdata, 16'h55AA);
      checkVal("t4_dm_ack", dm_ack, c == 4);
      if (c == 4) checkVal("t4_dm_rdata", dm_rdata, 16'h1234);
    end
    checkVal("t4_mem_written", memArr[12'h300], 16'h55AA);

    // T5: IF cancelled in cycle 2; DM load of 0x0300 at cycle 5 issues in 6.
    for (int c = 0; c <= 10; c++) begin
      nextCycle();
      if (c == 0) begin if_req = 1; if_addr = 16'h0010; end
      if (c == 2) if_req = 0;
      if (c == 5) begin dm_req = 1; dm_we = 0; dm_addr = 16'h0300; end
      if (c == 10) dm_req = 0;
      @(negedge clk);
      checkVal("t5_if_ack", if_ack, 0);
      checkVal("t5_mem_en", mem_en, (c == 1) || (c == 6));
      if (c == 4) checkVal("t5_if_rdata", if_rdata, 16'hB123);
      if (c == 6) checkVal("t5_addr", mem_addr, 16'h0300);
      checkVal("t5_dm_ack", dm_ack, c == 9);
      if (c == 9) checkVal("t5_dm_rdata", dm_rdata, 16'h55AA);
    end

    // T6: async reset in cycle 2 of an IF read; fresh IF read of 0x0200 at 5.
    for (int c = 0; c <= 10; c++) begin
      nextCycle();
      if (c == 0) begin if_req = 1; if_addr = 16'h0010; end
      if (c == 2) begin
        rst_n = 0; if_req = 0;
        #1;
        checkVal("t6_async_en", mem_en, 0);
        checkVal("t6_async_addr", mem_addr, 0);
        checkVal("t6_async_rdata", {if_rdata, dm_rdata}, 0);
      end
      if (c == 3) rst_n = 1;
      if (c == 5) begin if_req = 1; if_addr = 16'h0200; end
      if (c == 10) if_req = 0;
      @(negedge clk);
      checkVal("t6_mem_en", mem_en, (c == 1) || (c == 6));
      checkVal("t6_if_ack", if_ack, c == 9);
      if (c == 9) checkVal("t6_if_rdata", if_rdata, 16'h1234);
      checkVal("t6_dm_ack", dm_ack, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
